fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the core's decode/execute logic. It owns the program counter and issues word-aligned requests to instruction memory over a request/grant/response handshake. Returned words go into a small prefetch FIFO, which presents (pc, instr) pairs to decode with valid/ready. On a jump or branch redirect it flushes the FIFO and silently drops any responses still in flight.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core types: architectural width, memory size and the fetch-to-decode entry.
// Pure declarations; no logic, no latency, no flow control.
package riscv_pkg;
  localparam int XLEN     = 32;
  localparam int MEM_SIZE = 65536;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t; a push is visible at the head one cycle later (no bypass).
// Push is dropped when full without a pop; flush empties the FIFO and wins over a same-cycle push.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       i_push,
  input  fetch_entry_t               i_push_dat,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_entry_t               o_head_dat,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  fetch_entry_t  r_mem [DEPTH];
  logic          w_pop, w_push;

  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_pop      = i_pop & ~o_empty;
  assign w_push     = i_push & (~o_full | w_pop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, requests imem, buffers responses; grant N -> instr_valid_o N+2.
// Requests stop when buffered + in-flight would exceed FIFO_DEPTH, so decode stalls never drop data.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(FIFO_DEPTH);

  logic            r_run;
  logic [XLEN-1:0] r_fetch_pc, r_resp_pc;
  logic [CW-1:0]   r_outstanding, r_stale;

  logic            w_pop, w_gnt, w_stale_rsp, w_live_rsp, w_any_rsp, w_push;
  logic            w_full, w_empty;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_need;
  logic [XLEN-1:0] w_redir_pc;
  fetch_entry_t    w_head, w_push_dat;

  assign w_redir_pc    = redirect_pc_i & ~XLEN'(3);
  assign instr_valid_o = ~w_empty;
  assign instr_o       = instr_valid_o ? w_head.instr : '0;
  assign pc_o          = instr_valid_o ? w_head.pc    : '0;
  assign w_pop         = instr_valid_o & instr_ready_i;

  // Slots already promised: buffered entries that survive this cycle plus in-flight live requests.
  assign w_need      = {1'b0, w_count} + {1'b0, r_outstanding} - (CW+1)'(w_pop);
  assign imem_req_o  = r_run & ~redirect_i & (w_need < LIMIT);
  assign imem_addr_o = r_run ? r_fetch_pc : '0;
  assign w_gnt       = imem_req_o & imem_gnt_i;

  assign w_stale_rsp = imem_rvalid_i & (r_stale != '0);
  assign w_live_rsp  = imem_rvalid_i & (r_stale == '0) & (r_outstanding != '0);
  assign w_any_rsp   = w_stale_rsp | w_live_rsp;
  assign w_push      = w_live_rsp & ~redirect_i;
  assign w_push_dat  = '{pc: r_resp_pc, instr: imem_rdata_i};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (redirect_i),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_run         <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_stale       <= '0;
    end else begin
      r_run <= 1'b1;
      if (redirect_i) begin
        r_fetch_pc    <= w_redir_pc;
        r_resp_pc     <= w_redir_pc;
        r_outstanding <= '0;
        // Any response this cycle, live or stale, retires one in-flight request before the rest go stale.
        r_stale       <= r_stale + r_outstanding + CW'(w_gnt) - CW'(w_any_rsp);
      end else begin
        if (w_gnt)       r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_live_rsp)  r_resp_pc  <= r_resp_pc + XLEN'(4);
        if (w_stale_rsp) r_stale    <= r_stale - CW'(1);
        r_outstanding <= r_outstanding + CW'(w_gnt) - CW'(w_live_rsp);
      end
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rstn_i)
    imem_rvalid_i |-> (r_stale != '0 || r_outstanding != '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(w_push && w_full && !w_pop));
endmodule
